// File: rtl/pc_pkg.sv
// Shared definitions for the fetch program counter.
// Holds the next-PC select codes, the trap FSM state encoding and field widths.
package pc_pkg;

    localparam int unsigned SEL_W = 2;
    localparam int unsigned IMM_W = 26;

    localparam logic [SEL_W-1:0] PC_SEQ = 2'b00;
    localparam logic [SEL_W-1:0] PC_BR  = 2'b01;
    localparam logic [SEL_W-1:0] PC_J   = 2'b10;
    localparam logic [SEL_W-1:0] PC_JR  = 2'b11;

    typedef enum logic {
        RUN  = 1'b0,
        TRAP = 1'b1
    } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack.
// A push onto a full stack overwrites the oldest entry. A pop of an empty stack
// does nothing. A push and a pop in the same cycle replace the top entry.
// Ports:
//   clk, rst   clock, synchronous active-high reset (empties the stack)
//   push       write push_data as the new top
//   pop        discard the top entry
//   push_data  W-bit return address
//   top        current top entry, 0 when empty
//   empty      stack holds no entries
module pc_ras #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;
    logic             do_pop;
    logic [PTR_W-1:0] top_idx;

    // ptr_q is the next write slot; the top entry sits just below it.
    assign top_idx = ptr_q - PTR_W'(1);
    assign empty   = (cnt_q == '0);
    assign top     = empty ? '0 : mem[top_idx];

    // Next pointer/count and write slot.
    always_comb begin
        ptr_d  = ptr_q;
        cnt_d  = cnt_q;
        wr_en  = 1'b0;
        wr_idx = ptr_q;
        do_pop = pop && (cnt_q != '0);
        if (push && do_pop) begin
            wr_en  = 1'b1;
            wr_idx = top_idx;
        end else if (push) begin
            wr_en  = 1'b1;
            wr_idx = ptr_q;
            ptr_d  = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (do_pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; stale contents are hidden by the occupancy count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with stall hold, exception/return FSM and optional
// return-address stack (built when the PC_RAS_EN macro is defined).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   stall               hold PC and all state
//   pc_sel              next-PC select: seq / branch / jump / jr
//   br_off              sign-extended word offset for branches
//   imm26               jump index
//   reg_tgt             register target for jr
//   link                with jump/jr: push pc_plus4 on the return stack
//   ras_pop             with jr: pop the return stack
//   exc, eret           exception request, return from exception
//   pc                  current PC
//   pc_plus4            pc + 4 (combinational)
//   epc                 saved exception PC
//   in_trap             trap FSM is in TRAP
//   misalign            one-cycle pulse: jr target low bits were nonzero
//   ras_top, ras_empty  return-stack top entry (0 when empty) and empty flag
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned   W         = 32,
    parameter logic [W-1:0]  RESET_VEC = W'(32'h3000),
    parameter logic [W-1:0]  EXC_VEC   = W'(32'h4180),
    parameter int unsigned   RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [SEL_W-1:0] pc_sel,
    input  logic [W-1:0]     br_off,
    input  logic [IMM_W-1:0] imm26,
    input  logic [W-1:0]     reg_tgt,
    input  logic             link,
    input  logic             ras_pop,
    input  logic             exc,
    input  logic             eret,
    output logic [W-1:0]     pc,
    output logic [W-1:0]     pc_plus4,
    output logic [W-1:0]     epc,
    output logic             in_trap,
    output logic             misalign,
    output logic [W-1:0]     ras_top,
    output logic             ras_empty
);

    pc_state_e    state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] epc_q, epc_d;
    logic         mis_q, mis_d;
    logic         take_flow;

    assign pc       = pc_q;
    assign epc      = epc_q;
    assign misalign = mis_q;
    assign in_trap  = (state_q == TRAP);
    assign pc_plus4 = pc_q + W'(4);

    // Next PC / FSM: trap entry beats stall, stall beats return, return beats flow.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        mis_d     = 1'b0;
        take_flow = 1'b0;
        if (exc && (state_q == RUN)) begin
            pc_d    = EXC_VEC;
            epc_d   = pc_q;
            state_d = TRAP;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (eret && (state_q == TRAP)) begin
            pc_d    = epc_q;
            state_d = RUN;
        end else begin
            take_flow = 1'b1;
            case (pc_sel)
                PC_SEQ: pc_d = pc_plus4;
                PC_BR:  pc_d = pc_plus4 + (br_off << 2);
                PC_J:   pc_d = {pc_plus4[W-1:28], imm26, 2'b00};
                PC_JR: begin
                    pc_d  = {reg_tgt[W-1:2], 2'b00};
                    mis_d = |reg_tgt[1:0];
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= RESET_VEC;
            epc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
        end
    end

`ifdef PC_RAS_EN
    logic ras_push;
    logic ras_pop_en;

    // Stack moves only when the jump/jr itself is taken.
    assign ras_push   = take_flow & link & pc_sel[1];
    assign ras_pop_en = take_flow & ras_pop & (pc_sel == PC_JR);

    pc_ras #(
        .W     (W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop_en),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_ras;

    // No stack: link/pop are inert and the stack always reads empty.
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign unused_ras = &{1'b0, link, ras_pop, take_flow, (RAS_DEPTH == 0)};
`endif

endmodule
